i2so_serializer: RTL and testbench

I2S transmit serializer; the output-direction counterpart of the i2s_in receive path. It accepts 32-bit stereo frames (left in [31:16], right in [15:0]) over an rts/rtr handshake from the output audio FIFO. It acts as I2S master: it divides clk down to generate i2so_sck and i2so_ws, and shifts data MSB-first on i2so_sd with the standard one-bit delay after each ws transition.

---
 rtl/i2s_pkg.sv | 26 ++
 rtl/i2so_clk_gen.sv | 41 ++++
 rtl/i2so_serializer.sv | 132 +++++++++++++
 tb/tb_i2so_serializer.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S constants and helpers used by the transmit serializer and the
// i2s_in receive path: frame layout, channel field ranges and ws slot map.
package i2s_pkg;

  localparam int FRAME_BITS = 32;
  localparam int CH_BITS    = 16;

  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

  localparam logic [4:0] SLOT_WS_RISE = 5'd15;
  localparam logic [4:0] SLOT_WS_FALL = 5'd31;

  localparam int LEFT_MSB  = 31;
  localparam int LEFT_LSB  = 16;
  localparam int RIGHT_MSB = 15;
  localparam int RIGHT_LSB = 0;

  typedef logic [FRAME_BITS-1:0] frame_t;

  // ws leads the channel MSB by one slot: right for slots 15..30, left otherwise.
  function automatic logic slot_ws(input logic [4:0] slot);
    return ((slot >= SLOT_WS_RISE) && (slot != SLOT_WS_FALL)) ? WS_RIGHT : WS_LEFT;
  endfunction

endpackage

// File: rtl/i2so_clk_gen.sv
// I2S bit-clock generator: divides clk by 2*CLK_DIV to produce sck, plus
// combinational rise/fall strobes that are high in the clk cycle whose edge
// toggles sck, so downstream logic updates on the same edge as sck.
module i2so_clk_gen #(
  parameter int CLK_DIV = 4,
  parameter int DIV_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sck,
  output logic sck_rise,
  output logic sck_fall
);

  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             div_tc;

  assign div_tc   = (div_cnt == DIV_TC);
  assign sck_rise = en & div_tc & ~sck;
  assign sck_fall = en & div_tc & sck;

  // Divider counter and sck toggle; held at zero while disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (div_tc) begin
      div_cnt <= '0;
      sck     <= ~sck;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2so_serializer.sv
// I2S transmit serializer (master). Accepts stereo frames over rts/rtr into a
// one-deep holding register and plays them MSB-first, slot s = frame[31-s],
// with ws one slot ahead of each channel MSB.
// Optional build macro I2SO_REPEAT_ON_UNDERRUN_EN: an underrun replays the last
// successfully loaded frame instead of silence.
module i2so_serializer
  import i2s_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int DIV_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rf_i2so_en,
  input  logic [FRAME_BITS-1:0] i2so_inp_data,
  input  logic                  i2so_inp_rts,
  output logic                  i2so_inp_rtr,
  output logic                  i2so_sck,
  output logic                  i2so_ws,
  output logic                  i2so_sd,
  output logic                  i2so_xfc,
  output logic                  i2so_ro_underrun
);

  logic       sck_rise;
  logic       sck_fall;
  frame_t     hold_data;
  logic       hold_vld;
  frame_t     shift_frame;
  logic [4:0] slot;
  logic [4:0] slot_nxt;
  logic       push;
  logic       frame_start;
  logic       load_ok;
  frame_t     underrun_frame;
  frame_t     load_frame;

  i2so_clk_gen #(
    .CLK_DIV (CLK_DIV),
    .DIV_W   (DIV_W)
  ) u_clk_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (rf_i2so_en),
    .sck      (i2so_sck),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall)
  );

  assign i2so_inp_rtr = ~hold_vld;
  assign push         = i2so_inp_rts & ~hold_vld;
  assign slot_nxt     = slot + 5'd1;
  // The frame boundary is the fall that wraps slot 31 into slot 0.
  assign frame_start  = sck_fall & (slot == SLOT_WS_FALL);
  assign load_ok      = frame_start & hold_vld;
  assign load_frame   = hold_vld ? hold_data : underrun_frame;

`ifdef I2SO_REPEAT_ON_UNDERRUN_EN
  frame_t last_frame;

  // Remember the most recent real frame so an underrun can replay it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_frame <= '0;
    end else if (load_ok) begin
      last_frame <= hold_data;
    end
  end

  assign underrun_frame = last_frame;
`else
  assign underrun_frame = '0;
`endif

  // One-deep holding register; fills independently of enable. A push and a
  // load never coincide because a push needs the register empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_data <= '0;
      hold_vld  <= 1'b0;
    end else if (push) begin
      hold_data <= i2so_inp_data;
      hold_vld  <= 1'b1;
    end else if (load_ok) begin
      hold_vld  <= 1'b0;
    end
  end

  // Slot sequencing, frame load, ws/sd generation and underrun tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot             <= SLOT_WS_FALL;
      shift_frame      <= '0;
      i2so_ws          <= WS_LEFT;
      i2so_sd          <= 1'b0;
      i2so_xfc         <= 1'b0;
      i2so_ro_underrun <= 1'b0;
    end else if (!rf_i2so_en) begin
      slot             <= SLOT_WS_FALL;
      shift_frame      <= '0;
      i2so_ws          <= WS_LEFT;
      i2so_sd          <= 1'b0;
      i2so_xfc         <= 1'b0;
      i2so_ro_underrun <= 1'b0;
    end else begin
      i2so_xfc <= 1'b0;
      if (sck_fall) begin
        slot    <= slot_nxt;
        i2so_ws <= slot_ws(slot_nxt);
        if (frame_start) begin
          shift_frame <= load_frame;
          i2so_sd     <= load_frame[FRAME_BITS-1];
          i2so_xfc    <= hold_vld;
          if (!hold_vld) begin
            i2so_ro_underrun <= 1'b1;
          end
        end else begin
          // 31 - slot is the bitwise inverse of a 5-bit slot index.
          i2so_sd <= shift_frame[~slot_nxt];
        end
      end
    end
  end

  // The divider can never report both sck edges in the same cycle.
  always @(posedge clk) begin
    if (rst) begin
      assert (!(sck_rise && sck_fall));
    end
  end

endmodule

// File: tb/tb_i2so_serializer.sv
// Directed bench for i2so_serializer with CLK_DIV=2 (sck period = 4 clks).
module tb_i2so_serializer;

  localparam int CLK_DIV = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        rf_i2so_en;
  logic [31:0] i2so_inp_data;
  logic        i2so_inp_rts;
  logic        i2so_inp_rtr;
  logic        i2so_sck;
  logic        i2so_ws;
  logic        i2so_sd;
  logic        i2so_xfc;
  logic        i2so_ro_underrun;

  int total = 0;
  int bad = 0;
  int xfc_cnt = 0;

  i2so_serializer #(
    .CLK_DIV (CLK_DIV),
    .DIV_W   (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .rf_i2so_en       (rf_i2so_en),
    .i2so_inp_data    (i2so_inp_data),
    .i2so_inp_rts     (i2so_inp_rts),
    .i2so_inp_rtr     (i2so_inp_rtr),
    .i2so_sck         (i2so_sck),
    .i2so_ws          (i2so_ws),
    .i2so_sd          (i2so_sd),
    .i2so_xfc         (i2so_xfc),
    .i2so_ro_underrun (i2so_ro_underrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (i2so_xfc === 1'b1) xfc_cnt++;

  // Waits for the next sck 1->0 seen between negedge samples; n = clks waited.
  task automatic wait_fall(output int n);
    logic prev;
    prev = i2so_sck;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (prev === 1'b1 && i2so_sck === 1'b0) return;
      prev = i2so_sck;
      if (n >= 64) begin
        total++;
        bad++;
        $display("FAIL wait_fall: no sck fall within 64 clks, sck=%b", i2so_sck);
        n = -1;
        return;
      end
    end
  endtask

  // Records sd/ws for slots 0..31 into bit 31-s; slot 0 is the current sample
  // unless wait_first asks to wait for the fall into it.
  task automatic capture_frame(input bit wait_first, output logic [31:0] sdb,
                               output logic [31:0] wsb, output int first_gap,
                               output int max_gap, output logic ur0,
                               output logic rtr0);
    int n;
    first_gap = 0;
    max_gap = 0;
    if (wait_first) begin
      wait_fall(n);
      first_gap = n;
    end
    sdb[31] = i2so_sd;
    wsb[31] = i2so_ws;
    ur0     = i2so_ro_underrun;
    rtr0    = i2so_inp_rtr;
    for (int s = 1; s < 32; s++) begin
      wait_fall(n);
      if (n < 0) max_gap = 999;
      else if (n > max_gap) max_gap = n;
      sdb[31-s] = i2so_sd;
      wsb[31-s] = i2so_ws;
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    i2so_inp_data = w;
    i2so_inp_rts  = 1'b1;
    @(posedge clk);
    #1;
    i2so_inp_rts  = 1'b0;
  endtask

  task automatic do_reset();
    rf_i2so_en    = 1'b0;
    i2so_inp_rts  = 1'b0;
    i2so_inp_data = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({i2so_sck, i2so_ws, i2so_sd, i2so_xfc, i2so_ro_underrun} !== 5'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 00000",
               {i2so_sck, i2so_ws, i2so_sd, i2so_xfc, i2so_ro_underrun});
    end
    total++;
    if (i2so_inp_rtr !== 1'b1) begin
      bad++;
      $display("FAIL reset_rtr: got %b want 1", i2so_inp_rtr);
    end
  endtask

  task automatic test_basic_frame();
    logic [31:0] sdb, wsb;
    logic [3:0]  seq;
    int fg, mg, c0;
    logic ur0, rtr0;
    do_reset();
    push_word(32'hA5A5_3C3C);
    @(negedge clk);
    c0 = xfc_cnt;
    rf_i2so_en = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      seq[3-n] = i2so_sck;
    end
    total++;
    if (seq !== 4'b0110) begin
      bad++;
      $display("FAIL basic_sck_startup: got %b want 0110", seq);
    end
    capture_frame(1'b0, sdb, wsb, fg, mg, ur0, rtr0);
    total++;
    if (sdb !== 32'hA5A5_3C3C) begin
      bad++;
      $display("FAIL basic_sd: got %h want a5a53c3c", sdb);
    end
    total++;
    if (wsb !== 32'h0001_FFFE) begin
      bad++;
      $display("FAIL basic_ws: got %h want 0001fffe", wsb);
    end
    total++;
    if (xfc_cnt - c0 !== 1) begin
      bad++;
      $display("FAIL basic_xfc_count: got %0d want 1", xfc_cnt - c0);
    end
    total++;
    if (ur0 !== 1'b0 || i2so_ro_underrun !== 1'b0) begin
      bad++;
      $display("FAIL basic_underrun: got %b%b want 00", ur0, i2so_ro_underrun);
    end
    total++;
    if (mg !== 2*CLK_DIV) begin
      bad++;
      $display("FAIL basic_slot_period: got %0d want %0d", mg, 2*CLK_DIV);
    end
    rf_i2so_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] sdb, wsb;
    int fg, mg, c0;
    logic ur0, rtr0;
    do_reset();
    c0 = xfc_cnt;
    i2so_inp_data = 32'h0001_8000;
    i2so_inp_rts  = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (i2so_inp_rtr !== 1'b0) begin
      bad++;
      $display("FAIL b2b_rtr_after_accept: got %b want 0", i2so_inp_rtr);
    end
    i2so_inp_data = 32'hFFFF_0000;
    @(negedge clk);
    rf_i2so_en = 1'b1;
    capture_frame(1'b1, sdb, wsb, fg, mg, ur0, rtr0);
    total++;
    if (sdb !== 32'h0001_8000) begin
      bad++;
      $display("FAIL b2b_frame1: got %h want 00018000", sdb);
    end
    total++;
    if (sdb[15] !== 1'b1) begin
      bad++;
      $display("FAIL b2b_right_msb_slot16: got %b want 1", sdb[15]);
    end
    total++;
    if (rtr0 !== 1'b1) begin
      bad++;
      $display("FAIL b2b_rtr_at_load1: got %b want 1", rtr0);
    end
    total++;
    if (i2so_inp_rtr !== 1'b0) begin
      bad++;
      $display("FAIL b2b_rtr_second_held: got %b want 0", i2so_inp_rtr);
    end
    capture_frame(1'b1, sdb, wsb, fg, mg, ur0, rtr0);
    i2so_inp_rts = 1'b0;
    total++;
    if (sdb !== 32'hFFFF_0000) begin
      bad++;
      $display("FAIL b2b_frame2: got %h want ffff0000", sdb);
    end
    total++;
    if (fg !== 2*CLK_DIV || mg !== 2*CLK_DIV) begin
      bad++;
      $display("FAIL b2b_no_gap: got first=%0d max=%0d want %0d", fg, mg, 2*CLK_DIV);
    end
    total++;
    if (rtr0 !== 1'b1 || ur0 !== 1'b0) begin
      bad++;
      $display("FAIL b2b_load2_state: got rtr=%b ur=%b want rtr=1 ur=0", rtr0, ur0);
    end
    total++;
    if (xfc_cnt - c0 !== 2) begin
      bad++;
      $display("FAIL b2b_xfc_count: got %0d want 2", xfc_cnt - c0);
    end
    rf_i2so_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_underrun();
    logic [31:0] sdb, wsb;
    int fg, mg, n;
    logic ur0, rtr0;
    do_reset();
    push_word(32'h1234_5678);
    @(negedge clk);
    rf_i2so_en = 1'b1;
    capture_frame(1'b1, sdb, wsb, fg, mg, ur0, rtr0);
    total++;
    if (sdb !== 32'h1234_5678 || ur0 !== 1'b0) begin
      bad++;
      $display("FAIL ur_frame1: got %h ur=%b want 12345678 ur=0", sdb, ur0);
    end
    capture_frame(1'b1, sdb, wsb, fg, mg, ur0, rtr0);
    total++;
    if (sdb !== 32'h0000_0000) begin
      bad++;
      $display("FAIL ur_frame2_silent: got %h want 00000000", sdb);
    end
    total++;
    if (ur0 !== 1'b1) begin
      bad++;
      $display("FAIL ur_flag_set: got %b want 1", ur0);
    end
    for (int i = 0; i < 3; i++) wait_fall(n);
    total++;
    if (i2so_ro_underrun !== 1'b1) begin
      bad++;
      $display("FAIL ur_flag_sticky: got %b want 1", i2so_ro_underrun);
    end
    rf_i2so_en = 1'b0;
    @(negedge clk);
    total++;
    if (i2so_ro_underrun !== 1'b0 || i2so_sck !== 1'b0) begin
      bad++;
      $display("FAIL ur_clear_on_disable: got ur=%b sck=%b want 0 0",
               i2so_ro_underrun, i2so_sck);
    end
  endtask

  task automatic test_disable_midframe();
    logic [31:0] sdb, wsb;
    int fg, mg, n, c0;
    logic ur0, rtr0;
    do_reset();
    push_word(32'hDEAD_BEEF);
    @(negedge clk);
    rf_i2so_en = 1'b1;
    wait_fall(n);
    push_word(32'hDEAD_BEEF);
    for (int i = 0; i < 10; i++) wait_fall(n);
    total++;
    if (i2so_sd !== 1'b1 || i2so_inp_rtr !== 1'b0) begin
      bad++;
      $display("FAIL dis_slot10_state: got sd=%b rtr=%b want 1 0", i2so_sd, i2so_inp_rtr);
    end
    rf_i2so_en = 1'b0;
    @(negedge clk);
    total++;
    if ({i2so_sck, i2so_ws, i2so_sd} !== 3'b000) begin
      bad++;
      $display("FAIL dis_outputs: got %b want 000", {i2so_sck, i2so_ws, i2so_sd});
    end
    total++;
    if (i2so_inp_rtr !== 1'b0) begin
      bad++;
      $display("FAIL dis_hold_kept: got rtr=%b want 0", i2so_inp_rtr);
    end
    @(negedge clk);
    c0 = xfc_cnt;
    rf_i2so_en = 1'b1;
    capture_frame(1'b1, sdb, wsb, fg, mg, ur0, rtr0);
    total++;
    if (sdb !== 32'hDEAD_BEEF || ur0 !== 1'b0) begin
      bad++;
      $display("FAIL dis_reenable_frame: got %h ur=%b want deadbeef ur=0", sdb, ur0);
    end
    total++;
    if (fg !== 2*CLK_DIV || xfc_cnt - c0 !== 1) begin
      bad++;
      $display("FAIL dis_reenable_timing: got gap=%0d xfc=%0d want %0d 1",
               fg, xfc_cnt - c0, 2*CLK_DIV);
    end
    rf_i2so_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int n, c0;
    do_reset();
    push_word(32'hFFFF_FFFF);
    @(negedge clk);
    rf_i2so_en = 1'b1;
    wait_fall(n);
    push_word(32'hFFFF_FFFF);
    for (int i = 0; i < 20; i++) wait_fall(n);
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({i2so_sck, i2so_ws, i2so_sd, i2so_inp_rtr} !== 4'b1110) begin
      bad++;
      $display("FAIL arst_pre_state: got %b want 1110",
               {i2so_sck, i2so_ws, i2so_sd, i2so_inp_rtr});
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if ({i2so_sck, i2so_ws, i2so_sd, i2so_xfc, i2so_ro_underrun} !== 5'b0) begin
      bad++;
      $display("FAIL arst_outputs: got %b want 00000",
               {i2so_sck, i2so_ws, i2so_sd, i2so_xfc, i2so_ro_underrun});
    end
    total++;
    if (i2so_inp_rtr !== 1'b1) begin
      bad++;
      $display("FAIL arst_rtr: got %b want 1", i2so_inp_rtr);
    end
    @(negedge clk);
    rst = 1'b1;
    c0 = xfc_cnt;
    wait_fall(n);
    total++;
    if (n !== 2*CLK_DIV || i2so_ro_underrun !== 1'b1 || i2so_sd !== 1'b0 || xfc_cnt !== c0) begin
      bad++;
      $display("FAIL arst_first_frame: got gap=%0d ur=%b sd=%b xfc=%0d want %0d 1 0 0",
               n, i2so_ro_underrun, i2so_sd, xfc_cnt - c0, 2*CLK_DIV);
    end
    rf_i2so_en = 1'b0;
    @(negedge clk);
  endtask

`ifdef I2SO_REPEAT_ON_UNDERRUN_EN
  task automatic test_repeat_on_underrun();
    logic [31:0] sdb, wsb;
    int fg, mg;
    logic ur0, rtr0;
    do_reset();
    push_word(32'h00FF_FF00);
    @(negedge clk);
    rf_i2so_en = 1'b1;
    capture_frame(1'b1, sdb, wsb, fg, mg, ur0, rtr0);
    total++;
    if (sdb !== 32'h00FF_FF00) begin
      bad++;
      $display("FAIL rep_frame1: got %h want 00ffff00", sdb);
    end
    capture_frame(1'b1, sdb, wsb, fg, mg, ur0, rtr0);
    total++;
    if (sdb !== 32'h00FF_FF00 || ur0 !== 1'b1) begin
      bad++;
      $display("FAIL rep_frame2: got %h ur=%b want 00ffff00 ur=1", sdb, ur0);
    end
    rf_i2so_en = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    rst           = 1'b0;
    rf_i2so_en    = 1'b0;
    i2so_inp_rts  = 1'b0;
    i2so_inp_data = '0;
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_underrun();
    test_disable_midframe();
    test_async_reset();
`ifdef I2SO_REPEAT_ON_UNDERRUN_EN
    test_repeat_on_underrun();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
